fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of one `fifo_valid_ready` instance between `N_REQ` upstream producers. Each producer gets a grant of up to `BURST` accepted beats, then the grant rotates. The arbiter sits between the producers (counters, key-driven sources) and the FIFO's `up_valid`/`up_ready`/`wr_data` port. It runs in the FIFO's clock domain.

---
 rtl/fifo_write_arbiter_pkg.sv | 14 +
 rtl/fifo_write_arbiter_if.sv | 11 +
 rtl/fifo_write_arbiter_picker.sv | 32 +++
 rtl/fifo_write_arbiter.sv | 98 +++++++++
 tb/tb_fifo_write_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and width helper for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int clog2_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// FIFO write-side handshake shared between the arbiter (master) and the FIFO (slave).
interface fifo_write_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] wr_data;

  modport master (output up_valid, output wr_data, input up_ready);
  modport slave  (input up_valid, input wr_data, output up_ready);
endinterface

// File: rtl/fifo_write_arbiter_picker.sv
// Round-robin winner selection: rotate so last_grant+1 is bit 0, take the lowest set bit, rotate back.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = clog2_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic             any,
  output logic [IW-1:0]    winner
);

  logic [N_REQ-1:0] rot;
  int start;
  int pos;

  always_comb begin
    rot   = '0;
    start = (int'(last_grant) + 1) % N_REQ;
    pos   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[(start + i) % N_REQ];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    any    = |req;
    winner = IW'((start + pos) % N_REQ);
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers, BURST beats per grant.
//
// state    | meaning
// ARB_IDLE | no grant held; picks the next requester after last_grant
// ARB_BUSY | grant_id owns the FIFO port; data/valid/ready pass through combinationally
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 4,
  parameter int BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*WIDTH-1:0]        req_data,
  output logic [N_REQ-1:0]              req_ready,
  fifo_write_arbiter_if.master          up,
  output logic [clog2_w(N_REQ)-1:0]     grant_id,
  output logic                          busy,
  output logic [clog2_w(BURST+1)-1:0]   beat_cnt
);

  localparam int IW = clog2_w(N_REQ);
  localparam int BW = clog2_w(BURST + 1);

  arb_state_t    state, state_n;
  logic [IW-1:0] grant_n;
  logic [IW-1:0] last_grant, last_grant_n;
  logic [BW-1:0] beat_n;
  logic          pick_any;
  logic [IW-1:0] pick_winner;
  logic          g_valid;
  logic          xfer;
  logic          up_valid_c;
  logic [WIDTH-1:0] wr_data_c;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= IW'(N_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_n;
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant_id;
    last_grant_n = last_grant;
    beat_n       = beat_cnt;
    req_ready    = '0;
    up_valid_c   = 1'b0;
    wr_data_c    = '0;
    g_valid      = 1'b0;
    xfer         = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_n = pick_winner;
          beat_n  = '0;
          state_n = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        g_valid             = req_valid[grant_id];
        up_valid_c          = g_valid;
        wr_data_c           = req_data[int'(grant_id)*WIDTH +: WIDTH];
        req_ready[grant_id] = up.up_ready;
        xfer                = g_valid & up.up_ready;
        if (xfer) beat_n = beat_cnt + BW'(1);
        // A full FIFO with the owner still valid keeps the grant with no timeout.
        if ((xfer && (beat_cnt == BW'(BURST - 1))) || !g_valid) begin
          state_n      = ARB_IDLE;
          last_grant_n = grant_id;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  assign busy        = (state == ARB_BUSY);
  assign up.up_valid = up_valid_c;
  assign up.wr_data  = wr_data_c;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a small depth-4 FIFO model on the write port.
module tb_fifo_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [7:0] req_data;
  logic [1:0] req_ready;
  logic [0:0] grant_id;
  logic       busy;
  logic [2:0] beat_cnt;
  logic       rd_ready;
  int         fifo_cnt = 0;
  logic [3:0] written[$];
  logic [0:0] grants[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         idx0, idx1;
  logic       x0, x1, prev_busy;

  fifo_write_arbiter_if #(.WIDTH(4)) up_if ();

  fifo_write_arbiter #(.N_REQ(2), .WIDTH(4), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .up        (up_if),
    .grant_id  (grant_id),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  assign up_if.up_ready = (fifo_cnt < 4);

  always @(posedge clk) begin
    if (up_if.up_valid && up_if.up_ready) written.push_back(up_if.wr_data);
    fifo_cnt <= fifo_cnt + ((up_if.up_valid && up_if.up_ready) ? 1 : 0)
                         - ((rd_ready && fifo_cnt > 0) ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; rd_ready = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_checks++; if (beat_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_beat: got %0d want 0", beat_cnt); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    n_checks++; if (up_if.up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_up_valid: got %0b want 0", up_if.up_valid); end
    n_checks++; if (up_if.wr_data !== 4'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", up_if.wr_data); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    written.delete();
    req_valid = 2'b10; req_data = 8'h50;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL single_idle: got busy=%0b ready=%b want 0/00", busy, req_ready); end
    tick();
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL single_grant: got %0d want 1", grant_id); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b want 1", busy); end
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", req_ready); end
    n_checks++; if (up_if.up_valid !== 1'b1 || up_if.wr_data !== 4'h5) begin n_fail++; $display("FAIL single_pass: got v=%0b d=%h want 1/5", up_if.up_valid, up_if.wr_data); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (beat_cnt !== 3'd1) begin n_fail++; $display("FAIL single_beat: got %0d want 1", beat_cnt); end
    n_checks++; if (written.size() != 1 || written[0] !== 4'h5) begin n_fail++; $display("FAIL single_write: got n=%0d want one beat of 5", written.size()); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got busy=%0b want 0", busy); end
  endtask

  task automatic test_contention();
    logic [3:0] exp [15] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB, 4'hC,
                             4'h5, 4'h6, 4'h7, 4'h8, 4'hD, 4'hE, 4'hF};
    logic [0:0] exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    written.delete(); grants.delete();
    idx0 = 0; idx1 = 0; prev_busy = busy;
    for (int cyc = 0; cyc < 40 && !(idx0 == 8 && idx1 == 7); cyc++) begin
      req_valid = {idx1 < 7, idx0 < 8};
      req_data  = {4'(idx1 + 9), 4'(idx0 + 1)};
      #1;
      if (busy && !prev_busy) grants.push_back(grant_id);
      prev_busy = busy;
      x0 = req_ready[0] && req_valid[0];
      x1 = req_ready[1] && req_valid[1];
      tick();
      if (x0) idx0++;
      if (x1) idx1++;
    end
    req_valid = 2'b00;
    n_checks++; if (idx0 != 8 || idx1 != 7) begin n_fail++; $display("FAIL cont_budget: got idx0=%0d idx1=%0d want 8/7", idx0, idx1); end
    n_checks++; if (written.size() != 15) begin n_fail++; $display("FAIL cont_count: got %0d want 15", written.size()); end
    for (int i = 0; i < 15 && i < written.size(); i++) begin
      n_checks++; if (written[i] !== exp[i]) begin n_fail++; $display("FAIL cont_data[%0d]: got %h want %h", i, written[i], exp[i]); end
    end
    n_checks++; if (grants.size() != 4) begin n_fail++; $display("FAIL cont_grants: got %0d grants want 4", grants.size()); end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      n_checks++; if (grants[i] !== exp_g[i]) begin n_fail++; $display("FAIL cont_grant[%0d]: got %0d want %0d", i, grants[i], exp_g[i]); end
    end
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_end: got busy=%0b want 0", busy); end
  endtask

  task automatic test_stall();
    tick(); tick(); tick();
    written.delete();
    rd_ready = 1'b0; idx0 = 0;
    for (int cyc = 0; cyc < 12 && idx0 < 4; cyc++) begin
      req_valid = 2'b01;
      req_data  = {4'h0, 4'(idx0)};
      #1;
      x0 = req_ready[0] && req_valid[0];
      tick();
      if (x0) idx0++;
    end
    n_checks++; if (busy !== 1'b0 || up_if.up_ready !== 1'b0) begin n_fail++; $display("FAIL stall_exit: got busy=%0b up_ready=%0b want 0/0", busy, up_if.up_ready); end
    tick();
    n_checks++; if (busy !== 1'b1 || grant_id !== 1'b0 || beat_cnt !== 3'd0) begin n_fail++; $display("FAIL stall_regrant: got busy=%0b g=%0d beat=%0d want 1/0/0", busy, grant_id, beat_cnt); end
    req_valid = 2'b11; req_data = 8'hB4;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (req_ready !== 2'b00 || up_if.up_valid !== 1'b1 || beat_cnt !== 3'd0 || grant_id !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got ready=%b v=%0b beat=%0d g=%0d want 00/1/0/0", i, req_ready, up_if.up_valid, beat_cnt, grant_id);
      end
      tick();
    end
    n_checks++; if (written.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", written.size()); end
    for (int i = 0; i < 4 && i < written.size(); i++) begin
      n_checks++; if (written[i] !== 4'(i)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h want %h", i, written[i], 4'(i)); end
    end
    rd_ready = 1'b1;
    tick();
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_resume: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_checks++; if (written.size() != 5 || beat_cnt !== 3'd1) begin n_fail++; $display("FAIL stall_after: got n=%0d beat=%0d want 5/1", written.size(), beat_cnt); end
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_early_release();
    written.delete();
    req_valid = 2'b01; req_data = 8'h0C;
    tick();
    n_checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL early_grant: got g=%0d busy=%0b want 0/1", grant_id, busy); end
    tick(); tick();
    req_valid = 2'b10;
    #1;
    n_checks++; if (beat_cnt !== 3'd2 || up_if.up_valid !== 1'b0 || req_ready !== 2'b01) begin
      n_fail++; $display("FAIL early_drop: got beat=%0d v=%0b ready=%b want 2/0/01", beat_cnt, up_if.up_valid, req_ready);
    end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle: got busy=%0b want 0", busy); end
    tick();
    n_checks++; if (grant_id !== 1'b1 || req_ready !== 2'b10) begin n_fail++; $display("FAIL early_next: got g=%0d ready=%b want 1/10", grant_id, req_ready); end
    req_valid = 2'b00;
    tick();
    n_checks++; if (busy !== 1'b0 || written.size() != 2) begin n_fail++; $display("FAIL early_end: got busy=%0b n=%0d want 0/2", busy, written.size()); end
  endtask

  task automatic test_mid_reset();
    req_valid = 2'b11; req_data = 8'h93;
    tick();
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL mrst_grant: got %0d want 0", grant_id); end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || req_ready !== 2'b00 || beat_cnt !== 3'd0 || up_if.up_valid !== 1'b0) begin
      n_fail++; $display("FAIL mrst_state: got busy=%0b ready=%b beat=%0d v=%0b want 0/00/0/0", busy, req_ready, beat_cnt, up_if.up_valid);
    end
    rst = 1'b0;
    tick();
    n_checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL mrst_rearb: got g=%0d busy=%0b want 0/1", grant_id, busy); end
    req_valid = 2'b00;
    tick(); tick();
  endtask

  task automatic test_wrap();
    logic exp_busy;
    written.delete();
    req_valid = 2'b01; req_data = 8'h0A;
    for (int k = 1; k <= 15; k++) begin
      tick();
      exp_busy = (k % 5) != 0;
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL wrap_busy[%0d]: got %0b want %0b", k, busy, exp_busy); end
      if (exp_busy) begin
        n_checks++; if (grant_id !== 1'b0 || beat_cnt !== 3'((k % 5) - 1)) begin
          n_fail++; $display("FAIL wrap_state[%0d]: got g=%0d beat=%0d want 0/%0d", k, grant_id, beat_cnt, (k % 5) - 1);
        end
      end
    end
    req_valid = 2'b00;
    n_checks++; if (written.size() != 12) begin n_fail++; $display("FAIL wrap_count: got %0d want 12", written.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_early_release();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
